// File: rtl/rect_fill_engine.sv
// rect_fill_engine: rectangle-fill blitter driving the GPU video-memory write port.
// One command (origin, size, colour) is clipped to the framebuffer. Each pixel of the
// clipped area is then written in row-major order, one write per accepted cycle.
//
// Ports:
//   clk, rst_n_i          clock, synchronous active-low reset
//   start_i               command strobe, sampled only in IDLE
//   x0_i, y0_i, w_i, h_i  rectangle origin and size
//   color_i               fill colour
//   outline_i             border-only mode (present only with RECT_FILL_OUTLINE_EN)
//   v_ready_i             GPU accepts a write this cycle
//   v_we_o/v_addr_o/v_data_o  framebuffer write request (addr = y*FB_W + x)
//   busy_o                high while filling
//   done_o                one-cycle pulse at the end of every command
//
// Optional feature: define RECT_FILL_OUTLINE_EN to add outline_i. When outline_i is set,
// interior pixels are skipped at one cycle each.
module rect_fill_engine #(
    parameter int unsigned FB_W    = 80,
    parameter int unsigned FB_H    = 60,
    parameter int unsigned ADDR_W  = 13,
    parameter int unsigned DATA_W  = 12,
    parameter int unsigned COORD_W = 8
) (
    input  logic               clk,
    input  logic               rst_n_i,
    input  logic               start_i,
    input  logic [COORD_W-1:0] x0_i,
    input  logic [COORD_W-1:0] y0_i,
    input  logic [COORD_W-1:0] w_i,
    input  logic [COORD_W-1:0] h_i,
    input  logic [DATA_W-1:0]  color_i,
`ifdef RECT_FILL_OUTLINE_EN
    input  logic               outline_i,
`endif
    input  logic               v_ready_i,
    output logic               v_we_o,
    output logic [ADDR_W-1:0]  v_addr_o,
    output logic [DATA_W-1:0]  v_data_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam logic [COORD_W:0]  LP_FB_W_C = (COORD_W+1)'(FB_W);
    localparam logic [COORD_W:0]  LP_FB_H_C = (COORD_W+1)'(FB_H);
    localparam logic [COORD_W:0]  LP_ONE_C  = (COORD_W+1)'(1);
    localparam logic [ADDR_W-1:0] LP_FB_W_A = ADDR_W'(FB_W);
    localparam logic [ADDR_W-1:0] LP_ONE_A  = ADDR_W'(1);

    typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

    state_e              r_state;
    logic [COORD_W:0]    r_x0, r_x, r_y, r_x_end, r_y_end;
    logic [ADDR_W-1:0]   r_row_base;
    logic                r_we, r_busy, r_done;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
`ifdef RECT_FILL_OUTLINE_EN
    logic                r_outline;
    logic [COORD_W:0]    r_y0;
`endif

    // Command decode: clipping uses one extra bit so x0+w cannot overflow.
    logic [COORD_W:0]  w_x_sum, w_y_sum, w_x_end, w_y_end;
    logic              w_empty;
    logic [ADDR_W-1:0] w_row0;

    always_comb begin
        w_x_sum = {1'b0, x0_i} + {1'b0, w_i};
        w_y_sum = {1'b0, y0_i} + {1'b0, h_i};
        w_x_end = (w_x_sum > LP_FB_W_C) ? LP_FB_W_C : w_x_sum;
        w_y_end = (w_y_sum > LP_FB_H_C) ? LP_FB_H_C : w_y_sum;
        w_empty = (w_i == '0) || (h_i == '0) ||
                  ({1'b0, x0_i} >= LP_FB_W_C) || ({1'b0, y0_i} >= LP_FB_H_C);
        // Only multiply at command start; the scan loop steps row_base by FB_W.
        w_row0  = ADDR_W'(y0_i) * LP_FB_W_A;
    end

    // Scan stepping: next pixel position and its address.
    logic [COORD_W:0]  w_x_inc, w_y_inc, w_nx, w_ny;
    logic [ADDR_W-1:0] w_nbase, w_naddr;
    logic              w_last_col, w_last_row, w_step, w_nskip;

    always_comb begin
        w_x_inc    = r_x + LP_ONE_C;
        w_y_inc    = r_y + LP_ONE_C;
        w_last_col = (w_x_inc == r_x_end);
        w_last_row = (w_y_inc == r_y_end);
        w_nx       = w_x_inc;
        w_ny       = r_y;
        w_nbase    = r_row_base;
        w_naddr    = r_addr + LP_ONE_A;
        if (w_last_col) begin
            w_nx    = r_x0;
            w_ny    = w_y_inc;
            w_nbase = r_row_base + LP_FB_W_A;
            w_naddr = w_nbase + ADDR_W'(r_x0);
        end
`ifdef RECT_FILL_OUTLINE_EN
        w_nskip = r_outline && (w_ny != r_y0) && (w_ny != r_y_end - LP_ONE_C) &&
                  (w_nx != r_x0) && (w_nx != r_x_end - LP_ONE_C);
`else
        w_nskip = 1'b0;
`endif
        // A skipped pixel (we low) advances without waiting on the GPU.
        w_step = r_we ? v_ready_i : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            r_state    <= StIdle;
            r_x0       <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_x_end    <= '0;
            r_y_end    <= '0;
            r_row_base <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef RECT_FILL_OUTLINE_EN
            r_outline  <= 1'b0;
            r_y0       <= '0;
`endif
        end else begin
            case (r_state)
                StIdle: begin
                    r_done <= 1'b0;
                    if (start_i) begin
                        r_x0       <= {1'b0, x0_i};
                        r_x        <= {1'b0, x0_i};
                        r_y        <= {1'b0, y0_i};
                        r_x_end    <= w_x_end;
                        r_y_end    <= w_y_end;
                        r_row_base <= w_row0;
`ifdef RECT_FILL_OUTLINE_EN
                        r_outline  <= outline_i;
                        r_y0       <= {1'b0, y0_i};
`endif
                        if (w_empty) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                        end else begin
                            // First pixel (x0,y0) is always on the border, never skipped.
                            r_state <= StFill;
                            r_busy  <= 1'b1;
                            r_we    <= 1'b1;
                            r_addr  <= w_row0 + ADDR_W'(x0_i);
                            r_data  <= color_i;
                        end
                    end
                end
                StFill: begin
                    if (w_step) begin
                        if (w_last_col && w_last_row) begin
                            r_state <= StDone;
                            r_we    <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_addr  <= '0;
                            r_data  <= '0;
                        end else begin
                            r_x        <= w_nx;
                            r_y        <= w_ny;
                            r_row_base <= w_nbase;
                            r_addr     <= w_naddr;
                            r_we       <= !w_nskip;
                        end
                    end
                end
                StDone: begin
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign v_we_o   = r_we;
    assign v_addr_o = r_addr;
    assign v_data_o = r_data;
    assign busy_o   = r_busy;
    assign done_o   = r_done;

endmodule

// File: tb/tb_rect_fill_engine.sv
module tb_rect_fill_engine;

    logic        clk = 1'b0;
    logic        rst_n_i, start_i, v_ready_i;
    logic [7:0]  x0_i, y0_i, w_i, h_i;
    logic [11:0] color_i;
    logic        v_we_o, busy_o, done_o;
    logic [12:0] v_addr_o;
    logic [11:0] v_data_o;
`ifdef RECT_FILL_OUTLINE_EN
    logic        outline_i = 1'b0;
`endif

    rect_fill_engine dut (
        .clk       (clk),
        .rst_n_i   (rst_n_i),
        .start_i   (start_i),
        .x0_i      (x0_i),
        .y0_i      (y0_i),
        .w_i       (w_i),
        .h_i       (h_i),
        .color_i   (color_i),
`ifdef RECT_FILL_OUTLINE_EN
        .outline_i (outline_i),
`endif
        .v_ready_i (v_ready_i),
        .v_we_o    (v_we_o),
        .v_addr_o  (v_addr_o),
        .v_data_o  (v_data_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int ph      = 0;
    logic bp_en = 1'b0;

    int   wr_addr_q[$];
    int   wr_data_q[$];
    int   wr_cyc_q[$];
    int   exp_q[$];
    int   done_cnt = 0;
    int   done_cyc = -1;
    logic busy_seen = 1'b0;

    logic        prev_we = 1'b0, prev_ready = 1'b0;
    logic [12:0] prev_addr = '0;
    logic [11:0] prev_data = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Ready pattern 1,0,0,1 when backpressure is on; changes well away from the edge.
    always @(posedge clk) begin
        #1;
        ph = ph + 1;
    end
    assign v_ready_i = !bp_en || (ph % 4 == 0) || (ph % 4 == 3);

    // Monitor at the falling edge: a write seen here completes at the next rising edge.
    always @(negedge clk) begin
        if (rst_n_i) begin
            if (v_we_o && v_ready_i) begin
                wr_addr_q.push_back(int'(v_addr_o));
                wr_data_q.push_back(int'(v_data_o));
                wr_cyc_q.push_back(cyc);
            end
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy_o) busy_seen = 1'b1;
            if (prev_we && !prev_ready)
                check_eq("hold_stable", 32'({v_we_o, v_addr_o, v_data_o}),
                         32'({prev_we, prev_addr, prev_data}));
        end
        prev_we    <= rst_n_i ? v_we_o : 1'b0;
        prev_ready <= v_ready_i;
        prev_addr  <= v_addr_o;
        prev_data  <= v_data_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int x0, input int y0, input int w, input int h,
                         input int col, output int s);
        x0_i    = 8'(x0);
        y0_i    = 8'(y0);
        w_i     = 8'(w);
        h_i     = 8'(h);
        color_i = 12'(col);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        s = cyc;
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        done_cnt  = 0;
        done_cyc  = -1;
        busy_seen = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int n = 0;
        while (done_cnt == 0 && n < bound) begin
            tick();
            n++;
        end
        check_eq({tag, "_done_seen"}, 32'(done_cnt), 32'd1);
    endtask

    // Compare captured writes against exp_q; consec also checks one write per cycle from s.
    task automatic expect_writes(input string tag, input int s, input bit consec, input int col);
        check_eq({tag, "_count"}, 32'(wr_addr_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wr_addr_q.size(); i++) begin
            check_eq({tag, "_addr"}, 32'(wr_addr_q[i]), 32'(exp_q[i]));
            check_eq({tag, "_data"}, 32'(wr_data_q[i]), 32'(col));
            if (consec) check_eq({tag, "_cycle"}, 32'(wr_cyc_q[i]), 32'(s + i));
        end
    endtask

    int s;

    initial begin
        rst_n_i = 1'b0;
        start_i = 1'b0;
        x0_i = '0; y0_i = '0; w_i = '0; h_i = '0; color_i = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n_i = 1'b1;
        tick();
        check_eq("reset_we", 32'(v_we_o), 32'd0);
        check_eq("reset_busy", 32'(busy_o), 32'd0);
        check_eq("reset_done", 32'(done_o), 32'd0);
        check_eq("reset_writes", 32'(wr_addr_q.size()), 32'd0);

        // Basic fill.
        issue(2, 1, 3, 2, 'hF00, s);
        check_eq("basic_busy", 32'(busy_o), 32'd1);
        wait_done("basic", 50);
        exp_q = '{82, 83, 84, 162, 163, 164};
        expect_writes("basic", s, 1'b1, 'hF00);
        check_eq("basic_done_cycle", 32'(done_cyc), 32'(s + 6));
        tick();
        check_eq("basic_busy_after", 32'(busy_o), 32'd0);
        check_eq("basic_done_once", 32'(done_cnt), 32'd1);

        // Clipping at the bottom-right corner.
        issue(78, 58, 10, 10, 'h0AB, s);
        wait_done("clip", 50);
        exp_q = '{4718, 4719, 4798, 4799};
        expect_writes("clip", s, 1'b1, 'h0AB);
        check_eq("clip_done_cycle", 32'(done_cyc), 32'(s + 4));

        // Empty commands: zero width, then origin off the right edge.
        issue(5, 5, 0, 4, 'h123, s);
        wait_done("empty_w", 10);
        check_eq("empty_w_writes", 32'(wr_addr_q.size()), 32'd0);
        check_eq("empty_w_done_cycle", 32'(done_cyc), 32'(s));
        check_eq("empty_w_busy", 32'(busy_seen), 32'd0);
        tick();
        issue(80, 5, 3, 3, 'h123, s);
        wait_done("empty_x", 10);
        check_eq("empty_x_writes", 32'(wr_addr_q.size()), 32'd0);
        check_eq("empty_x_done_cycle", 32'(done_cyc), 32'(s));
        check_eq("empty_x_busy", 32'(busy_seen), 32'd0);
        tick();

        // Backpressure, with a start pulse mid-fill that must be ignored.
        bp_en = 1'b1;
        issue(2, 1, 3, 2, 'h0F0, s);
        repeat (3) tick();
        x0_i = 8'd0; y0_i = 8'd0; w_i = 8'd1; h_i = 8'd1; color_i = 12'h555;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_done("bp", 100);
        bp_en = 1'b0;
        exp_q = '{82, 83, 84, 162, 163, 164};
        expect_writes("bp", s, 1'b0, 'h0F0);
        if (wr_cyc_q.size() > 0)
            check_eq("bp_done_cycle", 32'(done_cyc), 32'(wr_cyc_q[wr_cyc_q.size() - 1] + 1));
        repeat (4) tick();
        check_eq("bp_no_extra_writes", 32'(wr_addr_q.size()), 32'd6);
        check_eq("bp_no_extra_done", 32'(done_cnt), 32'd1);
        check_eq("bp_idle_busy", 32'(busy_o), 32'd0);

        // Reset in the middle of a fill.
        issue(2, 1, 3, 2, 'hF00, s);
        begin
            int n = 0;
            while (wr_addr_q.size() < 2 && n < 20) begin
                tick();
                n++;
            end
        end
        rst_n_i = 1'b0;
        repeat (2) tick();
        rst_n_i = 1'b1;
        repeat (3) tick();
        check_eq("rst_mid_writes", 32'(wr_addr_q.size()), 32'd2);
        check_eq("rst_mid_no_done", 32'(done_cnt), 32'd0);
        check_eq("rst_mid_we", 32'(v_we_o), 32'd0);
        check_eq("rst_mid_busy", 32'(busy_o), 32'd0);
        issue(2, 1, 3, 2, 'h00F, s);
        wait_done("after_rst", 50);
        exp_q = '{82, 83, 84, 162, 163, 164};
        expect_writes("after_rst", s, 1'b1, 'h00F);
        check_eq("after_rst_done_cycle", 32'(done_cyc), 32'(s + 6));

`ifdef RECT_FILL_OUTLINE_EN
        // 4x4 outline: interior offsets 5, 6, 9, 10 are skipped, scan still takes 16 cycles.
        tick();
        outline_i = 1'b1;
        issue(0, 0, 4, 4, 'hFFF, s);
        outline_i = 1'b0;
        wait_done("outline", 50);
        exp_q = '{0, 1, 2, 3, 80, 83, 160, 163, 240, 241, 242, 243};
        expect_writes("outline", s, 1'b0, 'hFFF);
        check_eq("outline_done_cycle", 32'(done_cyc), 32'(s + 16));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
